lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 39 +++
 rtl/lsu_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Core/memory bus bundle for lsu_ctrl; signal names are from the controller's
// point of view (i_* driven into it, o_* driven by it).
interface lsu_ctrl_if;
    // Core side
    logic        i_lsu_req;
    logic        i_lsu_wren;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_lsu_wdata;
    logic [1:0]  i_data_type;
    logic        i_unsigned;
    logic        o_stall;
    logic        o_lsu_done;
    logic [31:0] o_lsu_rdata;
    logic        o_lsu_err;
    logic        o_misaligned;
    // Memory side: o_mem_req is held until i_mem_ack; i_mem_rdata is valid
    // in the same cycle as i_mem_ack, and ack is only honoured while requesting.
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    modport master (
        output i_lsu_req, i_lsu_wren, i_lsu_addr, i_lsu_wdata, i_data_type, i_unsigned,
        output i_mem_ack, i_mem_rdata,
        input  o_stall, o_lsu_done, o_lsu_rdata, o_lsu_err, o_misaligned,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask
    );

    modport slave (
        input  i_lsu_req, i_lsu_wren, i_lsu_addr, i_lsu_wdata, i_data_type, i_unsigned,
        input  i_mem_ack, i_mem_rdata,
        output o_stall, o_lsu_done, o_lsu_rdata, o_lsu_err, o_misaligned,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: IDLE/REQ/DONE sequencer with lane steering,
// load extension and ack timeout. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    lsu_ctrl_if.slave  bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic [3:0]       mem_bmask_q;
    logic [1:0]       dtype_q;
    logic [1:0]       addr_lo_q;
    logic             uns_q;
    logic             done_q;
    logic             err_q;
    logic [31:0]      rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    logic             mis_q;
`endif

    logic [3:0]       mem_bmask_d;
    logic [31:0]      mem_wdata_d;
    logic [31:0]      rdata_d;
    logic [7:0]       lane_b;
    logic [15:0]      lane_h;
    logic             trap_d;

    // Lane enables and replicated store data from the incoming request.
    always_comb begin
        mem_bmask_d = 4'b1111;
        mem_wdata_d = bus.i_lsu_wdata;
        case (bus.i_data_type)
            DT_HALF: begin
                mem_bmask_d = 4'b0011 << {bus.i_lsu_addr[1], 1'b0};
                mem_wdata_d = {2{bus.i_lsu_wdata[15:0]}};
            end
            DT_BYTE: begin
                mem_bmask_d = 4'b0001 << bus.i_lsu_addr[1:0];
                mem_wdata_d = {4{bus.i_lsu_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Load lane selection and extension, using the captured request attributes.
    always_comb begin
        lane_b = bus.i_mem_rdata[7:0];
        case (addr_lo_q)
            2'd1:    lane_b = bus.i_mem_rdata[15:8];
            2'd2:    lane_b = bus.i_mem_rdata[23:16];
            2'd3:    lane_b = bus.i_mem_rdata[31:24];
            default: lane_b = bus.i_mem_rdata[7:0];
        endcase
        lane_h = addr_lo_q[1] ? bus.i_mem_rdata[31:16] : bus.i_mem_rdata[15:0];
        case (dtype_q)
            DT_HALF: rdata_d = {{16{~uns_q & lane_h[15]}}, lane_h};
            DT_BYTE: rdata_d = {{24{~uns_q & lane_b[7]}}, lane_b};
            default: rdata_d = bus.i_mem_rdata;
        endcase
        if (mem_we_q) begin
            rdata_d = 32'h0;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        trap_d = 1'b0;
        case (bus.i_data_type)
            DT_HALF: trap_d = bus.i_lsu_addr[0];
            DT_BYTE: trap_d = 1'b0;
            default: trap_d = |bus.i_lsu_addr[1:0];
        endcase
    end
`else
    assign trap_d = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_bmask_q <= 4'h0;
            dtype_q     <= 2'b00;
            addr_lo_q   <= 2'b00;
            uns_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            // Completion flags are single-cycle; only the transition into DONE raises them.
            done_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.i_lsu_req) begin
                        mem_we_q    <= bus.i_lsu_wren;
                        mem_addr_q  <= {bus.i_lsu_addr[31:2], 2'b00};
                        mem_wdata_q <= mem_wdata_d;
                        mem_bmask_q <= mem_bmask_d;
                        dtype_q     <= bus.i_data_type;
                        addr_lo_q   <= bus.i_lsu_addr[1:0];
                        uns_q       <= bus.i_unsigned;
                        cnt_q       <= '0;
                        if (trap_d) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
                            mis_q   <= 1'b1;
`endif
                        end else begin
                            state_q   <= REQ;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (bus.i_mem_ack) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        rdata_q   <= rdata_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_stall     = ~i_reset & (((state_q == IDLE) & bus.i_lsu_req) | (state_q == REQ));
    assign bus.o_lsu_done  = done_q;
    assign bus.o_lsu_rdata = rdata_q;
    assign bus.o_lsu_err   = err_q;
    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_bmask = mem_bmask_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.o_misaligned = mis_q;
`else
    assign bus.o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl (default TIMEOUT_CYCLES=16).
module tb_lsu_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_req(input logic wren, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] dt, input logic uns);
        bus.i_lsu_req   = 1'b1;
        bus.i_lsu_wren  = wren;
        bus.i_lsu_addr  = addr;
        bus.i_lsu_wdata = wdata;
        bus.i_data_type = dt;
        bus.i_unsigned  = uns;
    endtask

    // Load acked on the first REQ cycle; called at the start of an IDLE cycle.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] dt,
                           input logic uns, input logic [31:0] word, input logic [3:0] exp_bmask,
                           input logic [31:0] exp_maddr, input logic [31:0] exp_rdata);
        drive_req(1'b0, addr, 32'h0, dt, uns);
        settle();
        chk({tag, "_c0_stall"}, bus.o_stall, 1);
        tick();
        bus.i_lsu_req   = 1'b0;
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = word;
        settle();
        chk({tag, "_memreq"}, bus.o_mem_req, 1);
        chk({tag, "_maddr"}, bus.o_mem_addr, exp_maddr);
        chk({tag, "_bmask"}, bus.o_mem_bmask, exp_bmask);
        tick();
        bus.i_mem_ack = 1'b0;
        settle();
        chk({tag, "_done"}, bus.o_lsu_done, 1);
        chk({tag, "_rdata"}, bus.o_lsu_rdata, exp_rdata);
        chk({tag, "_err"}, bus.o_lsu_err, 0);
        chk({tag, "_mis"}, bus.o_misaligned, 0);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.i_lsu_req   = 1'b1;
        bus.i_lsu_wren  = 1'b0;
        bus.i_lsu_addr  = 32'h0;
        bus.i_lsu_wdata = 32'h0;
        bus.i_data_type = 2'b00;
        bus.i_unsigned  = 1'b0;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = 32'h0;
        #1 rst = 1'b1;
        #1;
        // Reset state, with a request pending that must not show as stall
        chk("rst_stall", bus.o_stall, 0);
        chk("rst_memreq", bus.o_mem_req, 0);
        chk("rst_done", bus.o_lsu_done, 0);
        chk("rst_rdata", bus.o_lsu_rdata, 0);
        chk("rst_err", bus.o_lsu_err, 0);
        chk("rst_mis", bus.o_misaligned, 0);
        chk("rst_bmask", bus.o_mem_bmask, 0);
        chk("rst_maddr", bus.o_mem_addr, 0);
        chk("rst_wdata", bus.o_mem_wdata, 0);
        chk("rst_we", bus.o_mem_we, 0);
        tick();
        tick();

        // LB 0x103 issued in the same cycle reset drops
        rst = 1'b0;
        drive_req(1'b0, 32'h103, 32'h0, 2'b10, 1'b0);
        settle();
        chk("lb_c0_stall", bus.o_stall, 1);
        chk("lb_c0_memreq", bus.o_mem_req, 0);
        tick();
        bus.i_lsu_req   = 1'b0;
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 32'h80FF_1234;
        settle();
        chk("lb_c1_memreq", bus.o_mem_req, 1);
        chk("lb_c1_maddr", bus.o_mem_addr, 32'h100);
        chk("lb_c1_bmask", bus.o_mem_bmask, 4'b1000);
        chk("lb_c1_we", bus.o_mem_we, 0);
        chk("lb_c1_done", bus.o_lsu_done, 0);
        tick();
        bus.i_mem_ack = 1'b0;
        settle();
        chk("lb_c2_done", bus.o_lsu_done, 1);
        chk("lb_c2_rdata", bus.o_lsu_rdata, 32'hFFFF_FF80);
        chk("lb_c2_err", bus.o_lsu_err, 0);
        chk("lb_c2_stall", bus.o_stall, 0);
        chk("lb_c2_memreq", bus.o_mem_req, 0);
        tick();
        settle();
        chk("lb_c3_done", bus.o_lsu_done, 0);
        chk("lb_c3_rdata_hold", bus.o_lsu_rdata, 32'hFFFF_FF80);

        // SH 0x202, with a stray request held during REQ and DONE
        drive_req(1'b1, 32'h202, 32'h0000_ABCD, 2'b01, 1'b0);
        tick();
        bus.i_lsu_addr  = 32'h0000_0F00;
        bus.i_lsu_wdata = 32'h1111_2222;
        settle();
        chk("sh_c1_wdata", bus.o_mem_wdata, 32'hABCD_ABCD);
        chk("sh_c1_bmask", bus.o_mem_bmask, 4'b1100);
        chk("sh_c1_we", bus.o_mem_we, 1);
        chk("sh_c1_maddr", bus.o_mem_addr, 32'h200);
        chk("sh_c1_stall", bus.o_stall, 1);
        tick();
        bus.i_mem_ack = 1'b1;
        settle();
        chk("sh_c2_stall", bus.o_stall, 1);
        chk("sh_c2_maddr", bus.o_mem_addr, 32'h200);
        tick();
        bus.i_mem_ack = 1'b0;
        settle();
        chk("sh_c3_done", bus.o_lsu_done, 1);
        chk("sh_c3_rdata", bus.o_lsu_rdata, 0);
        chk("sh_c3_stall", bus.o_stall, 0);
        tick();
        bus.i_lsu_req = 1'b0;
        settle();
        chk("sh_c4_stall", bus.o_stall, 0);
        tick();
        settle();
        chk("noqueue_memreq", bus.o_mem_req, 0);

        // Ack while idle is ignored
        bus.i_mem_ack = 1'b1;
        tick();
        bus.i_mem_ack = 1'b0;
        settle();
        chk("idle_ack_done", bus.o_lsu_done, 0);
        chk("idle_ack_memreq", bus.o_mem_req, 0);

        // SB lane replication
        drive_req(1'b1, 32'h1, 32'h1234_56A5, 2'b10, 1'b0);
        tick();
        bus.i_lsu_req = 1'b0;
        bus.i_mem_ack = 1'b1;
        settle();
        chk("sb_wdata", bus.o_mem_wdata, 32'hA5A5_A5A5);
        chk("sb_bmask", bus.o_mem_bmask, 4'b0010);
        tick();
        bus.i_mem_ack = 1'b0;
        tick();

        // LHU 0x0 with ack five cycles after the request
        drive_req(1'b0, 32'h0, 32'h1234_5678, 2'b01, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            bus.i_lsu_req   = 1'b0;
            bus.i_lsu_addr  = $urandom;
            bus.i_lsu_wdata = $urandom;
            bus.i_data_type = 2'($urandom_range(0, 3));
            settle();
            chk($sformatf("lhu_c%0d_memreq", c), bus.o_mem_req, 1);
            chk($sformatf("lhu_c%0d_bmask", c), bus.o_mem_bmask, 4'b0011);
            chk($sformatf("lhu_c%0d_maddr", c), bus.o_mem_addr, 32'h0);
            chk($sformatf("lhu_c%0d_wdata", c), bus.o_mem_wdata, 32'h5678_5678);
            chk($sformatf("lhu_c%0d_done", c), bus.o_lsu_done, 0);
        end
        tick();
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = 32'h0000_8001;
        tick();
        bus.i_mem_ack = 1'b0;
        settle();
        chk("lhu_c6_done", bus.o_lsu_done, 1);
        chk("lhu_c6_rdata", bus.o_lsu_rdata, 32'h0000_8001);
        tick();

        // Further extraction patterns
        do_load("lh_hi", 32'h2, 2'b01, 1'b0, 32'h8001_0000, 4'b1100, 32'h0, 32'hFFFF_8001);
        do_load("lbu_b1", 32'h1, 2'b10, 1'b1, 32'h0000_F100, 4'b0010, 32'h0, 32'h0000_00F1);
        do_load("lb_pos", 32'h8, 2'b10, 1'b0, 32'h0000_007F, 4'b0001, 32'h8, 32'h0000_007F);
        do_load("dt11", 32'h4, 2'b11, 1'b0, 32'h89AB_CDEF, 4'b1111, 32'h4, 32'h89AB_CDEF);

        // LW timeout with no ack
        drive_req(1'b0, 32'h300, 32'h0, 2'b00, 1'b0);
        n = 0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            bus.i_lsu_req = 1'b0;
            settle();
            if (bus.o_mem_req === 1'b1 && bus.o_lsu_done === 1'b0) n++;
        end
        chk("to_req_cycles", n, 16);
        tick();
        settle();
        chk("to_done", bus.o_lsu_done, 1);
        chk("to_err", bus.o_lsu_err, 1);
        chk("to_rdata", bus.o_lsu_rdata, 0);
        chk("to_memreq", bus.o_mem_req, 0);
        tick();
        settle();
        chk("to_err_clear", bus.o_lsu_err, 0);

        // LW with ack on the final REQ cycle
        drive_req(1'b0, 32'h300, 32'h0, 2'b00, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            bus.i_lsu_req = 1'b0;
            if (c == 16) begin
                bus.i_mem_ack   = 1'b1;
                bus.i_mem_rdata = 32'h5A5A_1234;
            end
        end
        tick();
        bus.i_mem_ack = 1'b0;
        settle();
        chk("tolast_done", bus.o_lsu_done, 1);
        chk("tolast_err", bus.o_lsu_err, 0);
        chk("tolast_rdata", bus.o_lsu_rdata, 32'h5A5A_1234);
        tick();

        // Reset while in REQ
        drive_req(1'b0, 32'h400, 32'h0, 2'b00, 1'b0);
        tick();
        bus.i_lsu_req = 1'b0;
        settle();
        chk("mr_memreq_before", bus.o_mem_req, 1);
        #1 rst = 1'b1;
        #1;
        chk("mr_memreq", bus.o_mem_req, 0);
        chk("mr_stall", bus.o_stall, 0);
        chk("mr_maddr", bus.o_mem_addr, 0);
        chk("mr_bmask", bus.o_mem_bmask, 0);
        #1 rst = 1'b0;
        tick();
        do_load("post_rst", 32'h404, 2'b00, 1'b0, 32'h1357_9BDF, 4'b1111, 32'h404, 32'h1357_9BDF);

        // Misaligned word access at 0x102
`ifdef LSU_MISALIGN_TRAP_EN
        drive_req(1'b0, 32'h102, 32'h0, 2'b00, 1'b0);
        tick();
        bus.i_lsu_req = 1'b0;
        settle();
        chk("mis_done", bus.o_lsu_done, 1);
        chk("mis_err", bus.o_lsu_err, 1);
        chk("mis_flag", bus.o_misaligned, 1);
        chk("mis_memreq", bus.o_mem_req, 0);
        chk("mis_rdata", bus.o_lsu_rdata, 0);
        chk("mis_stall", bus.o_stall, 0);
        tick();
        settle();
        chk("mis_done_clear", bus.o_lsu_done, 0);
        chk("mis_memreq_after", bus.o_mem_req, 0);
`else
        do_load("lw_mis", 32'h102, 2'b00, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h100, 32'hDEAD_BEEF);
        do_load("lh_mis", 32'h3, 2'b01, 1'b0, 32'h7FFF_0000, 4'b1100, 32'h0, 32'h0000_7FFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
